keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/elevator_pkg.sv | 20 ++
 rtl/keypad_decode.sv | 42 ++++
 rtl/keypad_scanner.sv | 165 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared key codes and keypad FSM state encoding
package elevator_pkg;

    localparam logic [3:0] KEY_STAR     = 4'd11;
    localparam logic [3:0] KEY_HASH     = 4'd12;
    localparam logic [3:0] KEY_STARHASH = 4'd13;
    localparam logic [3:0] KEY_INVALID  = 4'd14;
    localparam logic [3:0] KEY_NONE     = 4'd15;

    // Key map bit r*3+c: only * (row3,col0) and # (row3,col2) pressed
    localparam logic [11:0] STAR_HASH_MAP = 12'hA00;

    typedef enum logic [1:0] {
        KP_IDLE     = 2'd0,
        KP_DEBOUNCE = 2'd1,
        KP_HELD     = 2'd2,
        KP_RELEASE  = 2'd3
    } kp_state_t;

endpackage

// File: rtl/keypad_decode.sv
// rtl/keypad_decode.sv - key map to key code decoder; STAR_HASH_EN enables the *# combo code
module keypad_decode
    import elevator_pkg::*;
(
    input  logic [11:0] key_map,
    output logic [3:0]  code
);

    logic [3:0] n_pressed;
    logic [3:0] pos;

    always_comb begin
        n_pressed = '0;
        pos       = '0;
        for (int i = 0; i < 12; i++) begin
            if (key_map[i]) begin
                n_pressed = n_pressed + 4'd1;
                pos       = 4'(i);
            end
        end
    end

    always_comb begin
        code = KEY_INVALID;
        if (n_pressed == 4'd0) begin
            code = KEY_NONE;
        end else if (n_pressed == 4'd1) begin
            case (pos)
                4'd9:    code = KEY_STAR;
                4'd10:   code = 4'd0;
                4'd11:   code = KEY_HASH;
                default: code = pos + 4'd1;
            endcase
        end
`ifdef STAR_HASH_EN
        else if (key_map == STAR_HASH_MAP) begin
            code = KEY_STARHASH;
        end
`endif
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 keypad column scanner with frame debounce and one-shot key strobe
module keypad_scanner
    import elevator_pkg::*;
#(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] ROW_in,
    output logic [2:0] COL_out,
    output logic [3:0] BCD_out,
    output logic       Key_Valid
);

    localparam logic [7:0] DWELL_LAST = 8'(SCAN_DIV - 1);
    localparam logic [3:0] DF         = 4'(DEBOUNCE_FRAMES);

    logic [3:0]  row_meta, row_sync;
    logic [1:0]  col_idx;
    logic [7:0]  dwell;
    logic [11:0] key_map;
    logic        frame_done;
    logic [3:0]  code;

    kp_state_t   state, state_nx;
    logic [3:0]  count, count_nx, count_sat;
    logic [3:0]  cand, cand_nx;
    logic        emit;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= ROW_in;
            row_sync <= row_meta;
        end
    end

    assign COL_out = ~(3'b001 << col_idx);

    // Rows are active-low; key_map holds 1 for a pressed key at bit row*3+col
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            col_idx    <= '0;
            dwell      <= '0;
            key_map    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (dwell == DWELL_LAST) begin
                dwell <= '0;
                case (col_idx)
                    2'd0: begin
                        {key_map[9], key_map[6], key_map[3], key_map[0]} <= ~row_sync;
                        col_idx <= 2'd1;
                    end
                    2'd1: begin
                        {key_map[10], key_map[7], key_map[4], key_map[1]} <= ~row_sync;
                        col_idx <= 2'd2;
                    end
                    2'd2: begin
                        {key_map[11], key_map[8], key_map[5], key_map[2]} <= ~row_sync;
                        col_idx    <= 2'd0;
                        frame_done <= 1'b1;
                    end
                    default: col_idx <= 2'd0;
                endcase
            end else begin
                dwell <= dwell + 8'd1;
            end
        end
    end

    keypad_decode u_decode (
        .key_map (key_map),
        .code    (code)
    );

    assign count_sat = (count == 4'hF) ? count : count + 4'd1;

    always_comb begin
        state_nx = state;
        count_nx = count;
        cand_nx  = cand;
        emit     = 1'b0;
        if (frame_done) begin
            case (state)
                KP_IDLE: begin
                    if (code != KEY_NONE && code != KEY_INVALID) begin
                        cand_nx = code;
                        if (DF <= 4'd1) begin
                            emit     = 1'b1;
                            state_nx = KP_HELD;
                            count_nx = '0;
                        end else begin
                            state_nx = KP_DEBOUNCE;
                            count_nx = 4'd1;
                        end
                    end
                end
                KP_DEBOUNCE: begin
                    if (code == cand) begin
                        count_nx = count_sat;
                        if (count_sat >= DF) begin
                            emit     = 1'b1;
                            state_nx = KP_HELD;
                            count_nx = '0;
                        end
                    end else begin
                        state_nx = KP_IDLE;
                        count_nx = '0;
                    end
                end
                KP_HELD: begin
                    if (code == KEY_NONE) begin
                        if (DF <= 4'd1) begin
                            state_nx = KP_IDLE;
                            count_nx = '0;
                        end else begin
                            state_nx = KP_RELEASE;
                            count_nx = 4'd1;
                        end
                    end
                end
                KP_RELEASE: begin
                    if (code == KEY_NONE) begin
                        count_nx = count_sat;
                        if (count_sat >= DF) begin
                            state_nx = KP_IDLE;
                            count_nx = '0;
                        end
                    end else begin
                        state_nx = KP_HELD;
                        count_nx = '0;
                    end
                end
                default: begin
                    state_nx = KP_IDLE;
                    count_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= KP_IDLE;
            count     <= '0;
            cand      <= KEY_NONE;
            BCD_out   <= KEY_NONE;
            Key_Valid <= 1'b0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            cand      <= cand_nx;
            Key_Valid <= emit;
            if (emit) begin
                BCD_out <= cand_nx;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_FRAMES=3)
module tb_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [2:0]  col_out;
    logic [3:0]  bcd_out;
    logic        key_valid;
    logic [11:0] keys;

    int n_vec    = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int kv_count = 0;

    logic [2:0] col_seq [3];

    localparam logic [11:0] K1   = 12'h001;
    localparam logic [11:0] K5   = 12'h010;
    localparam logic [11:0] K7   = 12'h040;
    localparam logic [11:0] K9   = 12'h100;
    localparam logic [11:0] K2_4 = 12'h00A;
    localparam logic [11:0] KSH  = 12'hA00;

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .ROW_in    (row_in),
        .COL_out   (col_out),
        .BCD_out   (bcd_out),
        .Key_Valid (key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad matrix: a pressed key shorts its row to its driven-low column
    always_comb begin
        row_in = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (keys[r*3+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (key_valid) kv_count++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_col", 12'(col_out), 12'(3'b110));
        check("rst_bcd", 12'(bcd_out), 12'hF);
        check("rst_kv", 12'(key_valid), 12'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        cyc      = 0;
        kv_count = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        keys  = '0;
        col_seq[0] = 3'b110;
        col_seq[1] = 3'b101;
        col_seq[2] = 3'b011;

        // Key 5 held 4+ frames: single strobe one cycle after 3rd frame_done
        keys = K5;
        do_reset();
        run_to(36);
        check("k5_none_early", 12'(kv_count), 12'd0);
        run_to(37);
        check("k5_kv", 12'(key_valid), 12'h1);
        check("k5_bcd", 12'(bcd_out), 12'h5);
        run_to(38);
        check("k5_kv_drop", 12'(key_valid), 12'h0);
        run_to(60);
        check("k5_single", 12'(kv_count), 12'd1);
        check("k5_bcd_hold", 12'(bcd_out), 12'h5);

        // Key 7 bouncing: present, absent, present x3
        keys = K7;
        do_reset();
        run_to(12);
        keys = '0;
        run_to(24);
        keys = K7;
        run_to(60);
        check("k7_none_early", 12'(kv_count), 12'd0);
        check("k7_bcd_early", 12'(bcd_out), 12'hF);
        run_to(61);
        check("k7_kv", 12'(key_valid), 12'h1);
        check("k7_bcd", 12'(bcd_out), 12'h7);
        run_to(84);
        check("k7_single", 12'(kv_count), 12'd1);

        // * and # together
        keys = KSH;
        do_reset();
        run_to(37);
`ifdef STAR_HASH_EN
        check("sh_kv", 12'(key_valid), 12'h1);
        check("sh_bcd", 12'(bcd_out), 12'hD);
`else
        check("sh_kv", 12'(key_valid), 12'h0);
        check("sh_bcd", 12'(bcd_out), 12'hF);
`endif
        run_to(72);
`ifdef STAR_HASH_EN
        check("sh_count", 12'(kv_count), 12'd1);
        check("sh_bcd_end", 12'(bcd_out), 12'hD);
`else
        check("sh_count", 12'(kv_count), 12'd0);
        check("sh_bcd_end", 12'(bcd_out), 12'hF);
`endif

        // Keys 2 and 4 together: invalid, column rotation checked every cycle
        keys = K2_4;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            check("col_seq", 12'(col_out), 12'(col_seq[(cyc / 4) % 3]));
            tick();
        end
        check("inv_count", 12'(kv_count), 12'd0);
        check("inv_bcd", 12'(bcd_out), 12'hF);

        // Key 1: press, short release, re-press, full release, press again
        keys = K1;
        do_reset();
        run_to(36);
        keys = '0;
        run_to(37);
        check("k1_kv", 12'(key_valid), 12'h1);
        check("k1_bcd", 12'(bcd_out), 12'h1);
        run_to(60);
        keys = K1;
        run_to(84);
        keys = '0;
        run_to(120);
        keys = K1;
        run_to(156);
        check("k1_no_reemit", 12'(kv_count), 12'd1);
        run_to(157);
        check("k1_kv2", 12'(key_valid), 12'h1);
        check("k1_bcd2", 12'(bcd_out), 12'h1);
        run_to(168);
        check("k1_count2", 12'(kv_count), 12'd2);

        // Key change while held, release, then reset during 2nd debounce frame of key 9
        kv_count = 0;
        keys = K9;
        run_to(180);
        keys = '0;
        run_to(216);
        keys = K9;
        run_to(234);
        check("k9_held_no_emit", 12'(kv_count), 12'd0);
        check("k9_bcd_pre", 12'(bcd_out), 12'h1);
        do_reset();
        run_to(36);
        check("k9_none_early", 12'(kv_count), 12'd0);
        run_to(37);
        check("k9_kv", 12'(key_valid), 12'h1);
        check("k9_bcd", 12'(bcd_out), 12'h9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
